// File: rtl/prog_lut_neuron.sv
// Runtime-programmable truth-table neuron: a config stream fills a 2**IN_BITS x OUT_BITS
// table, then a lookup stream reads it back through a 1-cycle registered output stage.
module prog_lut_neuron #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic                cfg_flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                loaded,
    output logic                cfg_err
);

    localparam int                 DEPTH     = 1 << IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_BITS-1:0]  r_wr_cnt;
    logic [IN_BITS-1:0]  w_wr_cnt_nxt;
    logic                r_cfg_err;
    logic                w_cfg_err_nxt;
    logic                r_out_valid;
    logic [OUT_BITS-1:0] r_out_data;
    logic [OUT_BITS-1:0] r_table [DEPTH];

    logic w_cfg_fire;
    logic w_in_fire;
    logic w_out_fire;
    logic w_at_end;

    assign cfg_ready  = (r_state == S_EMPTY) || (r_state == S_LOAD);
    assign in_ready   = (r_state == S_READY) && !cfg_flush && (!r_out_valid || out_ready);
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_at_end   = (r_wr_cnt == LAST_ADDR);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign loaded     = (r_state == S_READY);
    assign cfg_err    = r_cfg_err;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_cfg_err_nxt = r_cfg_err;

        case (r_state)
            S_EMPTY, S_LOAD: begin
                // EMPTY always sits at wr_cnt==0, so both states share one beat rule.
                if (w_cfg_fire) begin
                    if (w_at_end && cfg_last) begin
                        w_state_nxt  = S_READY;
                        w_wr_cnt_nxt = '0;
                    end else if (w_at_end || cfg_last) begin
                        w_state_nxt   = S_EMPTY;
                        w_wr_cnt_nxt  = '0;
                        w_cfg_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_LOAD;
                        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    end
                end
            end
            S_READY: begin
                if (cfg_flush) begin
                    w_state_nxt = (!r_out_valid || out_ready) ? S_EMPTY : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_wr_cnt  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    // NOTE: the table has no reset so it maps onto distributed RAM; it is never read before loaded=1.
    always_ff @(posedge clk) begin
        if (w_cfg_fire) begin
            r_table[r_wr_cnt] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_table[in_data];
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
